level_seq_tx: RTL

LEVEL_SEQ_TX -- requirements
Module: level_seq_tx

---
 rtl/level_pkg.sv | 38 +++
 rtl/level_shadow.sv | 39 +++
 rtl/level_seq_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/level_pkg.sv
`default_nettype none
// ============================================================================
// Module      : level_pkg
// Description : Shared definitions for the level sequencer slice: receiver
//               level encodings, tx FSM state encodings, the neutral symbol
//               and the sticky-max level update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package level_pkg;

    // Receiver level encodings as mirrored by shadow_lvl
    localparam logic [2:0] LVL_IDLE = 3'd0;
    localparam logic [2:0] LVL_S0   = 3'd1;
    localparam logic [2:0] LVL_S1   = 3'd2;
    localparam logic [2:0] LVL_S2   = 3'd3;
    localparam logic [2:0] LVL_S3   = 3'd4;

    // Transmit FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Symbol that never lowers the receiver level
    localparam logic [1:0] NEUTRAL_SYM = 2'b00;

    // Receiver level after seeing symbol sym while at level cur.
    // The increment is done at 3 bits so symbol 3 maps to level 4.
    function automatic logic [2:0] lvl_after_sym(input logic [2:0] cur,
                                                 input logic [1:0] sym);
        logic [2:0] inc;
        inc = {1'b0, sym} + 3'd1;
        return (inc > cur) ? inc : cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_shadow.sv
`default_nettype none
// ============================================================================
// Module      : level_shadow
// Description : Sticky-max mirror of the receiver level. Cleared by lvl_clr,
//               otherwise rises to dout+1 whenever that exceeds the current
//               level (so even the neutral symbol lifts idle to s0).
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-low reset
//               dout       - symbol being sent to the receiver
//               lvl_clr    - receiver reset pulse
//               shadow_lvl - mirrored receiver level (idle=0 .. s3=4)
// Revision    : 1.0 - initial release
// ============================================================================
module level_shadow
    import level_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dout,
    input  logic       lvl_clr,
    output logic [2:0] shadow_lvl
);

    logic [2:0] r_shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= LVL_IDLE;
        end else if (lvl_clr) begin
            r_shadow <= LVL_IDLE;
        end else begin
            r_shadow <= lvl_after_sym(r_shadow, dout);
        end
    end

    assign shadow_lvl = r_shadow;

endmodule
`default_nettype wire

// File: rtl/level_seq_tx.sv
`default_nettype none
// ============================================================================
// Module      : level_seq_tx
// Description : Drives a sticky-max level receiver to a requested level by
//               ramping one symbol per step, holding each step for a
//               programmable dwell. Clears the receiver first when the target
//               lies below its current level.
// Ports       : clk, rst           - clock / async active-low reset
//               req_valid/ready    - request handshake
//               req_level          - target receiver level (s0..s3)
//               req_dwell          - cycles per ramp step (0 acts as 1)
//               dout, dout_valid   - symbol to receiver and its strobe
//               lvl_clr            - one-cycle receiver reset pulse
//               shadow_lvl         - mirrored receiver level
//               done               - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module level_seq_tx
    import level_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_level,
    input  logic [DWELL_W-1:0] req_dwell,
    output logic [1:0]         dout,
    output logic               dout_valid,
    output logic               lvl_clr,
    output logic [2:0]         shadow_lvl,
    output logic               done
);

    localparam logic [DWELL_W-1:0] C_DWELL_ONE = DWELL_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [1:0]         r_lvl;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;

    logic [2:0]         w_tgt;
    logic [2:0]         w_req_tgt;
    logic [DWELL_W-1:0] w_dwell_in;
    logic [2:0]         w_shadow_nxt;
    logic               w_accept;
    logic               w_ramp_more;

    assign w_tgt      = {1'b0, r_lvl} + 3'd1;
    assign w_req_tgt  = {1'b0, req_level} + 3'd1;
    assign w_dwell_in = (req_dwell == '0) ? C_DWELL_ONE : req_dwell;
    assign w_accept   = (r_state == ST_IDLE) && req_valid;

    // Step/hold exits decide on the level the receiver will hold after this
    // cycle, so the final step goes straight to DONE without an extra step.
    assign w_shadow_nxt = lvl_after_sym(shadow_lvl, dout);
    assign w_ramp_more  = (w_shadow_nxt < w_tgt);

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    assign req_ready  = (r_state == ST_IDLE);
    assign lvl_clr    = (r_state == ST_CLEAR);
    assign dout_valid = (r_state == ST_STEP);
    assign done       = (r_state == ST_DONE);

    always_comb begin
        dout = NEUTRAL_SYM;
        if (r_state == ST_STEP) begin
            if (shadow_lvl == w_tgt) begin
                dout = r_lvl;
            end else begin
                // shadow never exceeds the target while stepping, so it is
                // 0..3 here; level 0 sends symbol 0, level k sends symbol k.
                dout = shadow_lvl[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (w_req_tgt < shadow_lvl) ? ST_CLEAR : ST_STEP;
                end
            end
            ST_CLEAR: w_state_nxt = ST_STEP;
            ST_STEP: begin
                if (r_dwell > C_DWELL_ONE) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = w_ramp_more ? ST_STEP : ST_DONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == C_DWELL_ONE) begin
                    w_state_nxt = w_ramp_more ? ST_STEP : ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_lvl   <= 2'd0;
            r_dwell <= C_DWELL_ONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_lvl   <= req_level;
                r_dwell <= w_dwell_in;
            end
            // Hold counter counts the remaining hold cycles down to 1
            if (r_state == ST_STEP) begin
                r_cnt <= r_dwell - C_DWELL_ONE;
            end else if (r_state == ST_HOLD) begin
                r_cnt <= r_cnt - C_DWELL_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver level mirror
    // ------------------------------------------------------------------
    level_shadow u_shadow (
        .clk        (clk),
        .rst        (rst),
        .dout       (dout),
        .lvl_clr    (lvl_clr),
        .shadow_lvl (shadow_lvl)
    );

endmodule
`default_nettype wire
